// File: rtl/microwave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microwave_pkg
// Description : Shared types and constants for the microwave keypad/timer
//               path: FSM state encoding, key value encoding with a "none"
//               flag, BCD digit type and the number of display digits.
// Revision    : 1.0 - initial release
// ============================================================================
package microwave_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_OFFER = 2'd2
  } state_t;

  // Key value: bit 4 set means no key; bits 3:0 hold the digit 0..9.
  typedef logic [4:0] key_t;
  localparam key_t KEY_NONE = 5'b1_0000;

  // The encoder reports 0 both for "no key" and for the 0 key, so the
  // separate zero_key level is what distinguishes a real 0 press.
  // Codes 10..15 are illegal and fold into the same path as code 0.
  function automatic key_t key_decode(input logic [3:0] encoded,
                                      input logic       zero_key);
    key_t k;
    if (encoded >= 4'd1 && encoded <= 4'd9) begin
      k = {1'b0, encoded};
    end else if (zero_key) begin
      k = 5'b0_0000;
    end else begin
      k = KEY_NONE;
    end
    return k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/time_entry_register_if.sv
`default_nettype none
// ============================================================================
// Module      : time_entry_register_if
// Description : Cook-time transfer bundle between the time entry register
//               (master) and the countdown timer (slave).
//   time_valid                          master -> slave, time offered
//   time_ready                          slave  -> master, time accepted
//   min_tens/min_ones/sec_tens/sec_ones master -> slave, BCD MM:SS
// Revision    : 1.0 - initial release
// ============================================================================
interface time_entry_register_if;
  import microwave_pkg::*;

  logic time_valid;
  logic time_ready;
  bcd_t min_tens;
  bcd_t min_ones;
  bcd_t sec_tens;
  bcd_t sec_ones;

  modport master (
    output time_valid,
    input  time_ready,
    output min_tens,
    output min_ones,
    output sec_tens,
    output sec_ones
  );

  modport slave (
    input  time_valid,
    output time_ready,
    input  min_tens,
    input  min_ones,
    input  sec_tens,
    input  sec_ones
  );

endinterface
`default_nettype wire

// File: rtl/key_press_detector.sv
`default_nettype none
// ============================================================================
// Module      : key_press_detector
// Description : Maps the encoder code plus the zero-key level to a key value
//               and produces a single press event per key press (edge from
//               NONE to a key). Disabling forces the history to NONE.
//   clk, rst   clock and asynchronous active-high reset
//   enable     keypad entry mode
//   encoded    encoder output (0 = none, 1..9 digits, 10..15 illegal)
//   zero_key   debounced 0-key level
//   key_digit  current key digit value (valid when press is high)
//   press      one-cycle press event, combinational from inputs/history
// Revision    : 1.0 - initial release
// ============================================================================
module key_press_detector
  import microwave_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       enable,
  input  wire logic [3:0] encoded,
  input  wire logic       zero_key,
  output bcd_t            key_digit,
  output logic            press
);

  key_t key_w;
  key_t key_prev_d;
  key_t key_prev_q;

  always_comb begin
    key_w      = key_decode(encoded, zero_key);
    // While disabled the history reads NONE, so a key still held when
    // enable rises produces one fresh press.
    key_prev_d = enable ? key_w : KEY_NONE;
    press      = enable && !key_w[4] && key_prev_q[4];
    key_digit  = key_w[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_prev_q <= KEY_NONE;
    end else begin
      key_prev_q <= key_prev_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_entry_register.sv
`default_nettype none
// ============================================================================
// Module      : time_entry_register
// Description : Builds a four-digit BCD MM:SS cook time from keypad presses,
//               shifting in from the right, and offers it to the countdown
//               timer over a valid/ready handshake on the start key.
//   clk, rst     clock and asynchronous active-high reset
//   enable       keypad entry mode
//   encoded      encoder digit code
//   zero_key     debounced 0-key level
//   start_key    one-cycle start request
//   cancel_key   one-cycle cancel request
//   digit_count  number of digits entered (0..4)
//   entry_error  one-cycle pulse after a rejected start
//   tif          transfer bundle (valid/ready + BCD digits), master side
// Revision    : 1.0 - initial release
// ============================================================================
module time_entry_register
  import microwave_pkg::*;
#(
  parameter int MAX_SEC_TENS = 5
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   enable,
  input  wire logic [3:0]             encoded,
  input  wire logic                   zero_key,
  input  wire logic                   start_key,
  input  wire logic                   cancel_key,
  output logic [2:0]                  digit_count,
  output logic                        entry_error,
  time_entry_register_if.master       tif
);

  localparam bcd_t       MAX_SEC_TENS_BCD = bcd_t'(MAX_SEC_TENS);
  localparam logic [2:0] FULL_COUNT       = 3'(NUM_DIGITS);

  bcd_t key_digit;
  logic press;

  key_press_detector u_key_press_detector (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .encoded   (encoded),
    .zero_key  (zero_key),
    .key_digit (key_digit),
    .press     (press)
  );

  // Element 0 is sec_ones, element NUM_DIGITS-1 is min_tens.
  state_t                     state_d,  state_q;
  bcd_t [NUM_DIGITS-1:0]      digits_d, digits_q;
  logic [2:0]                 count_d,  count_q;
  logic                       valid_d,  valid_q;
  logic                       error_d,  error_q;

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    valid_d  = valid_q;
    error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // No leading zeros: only a non-zero digit opens an entry.
        if (press && key_digit != 4'd0) begin
          digits_d[0] = key_digit;
          count_d     = 3'd1;
          state_d     = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (cancel_key) begin
          digits_d = '0;
          count_d  = 3'd0;
          state_d  = ST_IDLE;
        end else if (start_key && digits_q[1] <= MAX_SEC_TENS_BCD) begin
          state_d = ST_OFFER;
          valid_d = 1'b1;
        end else begin
          // A rejected start keeps the digits; a press that coincides with
          // it still lands because the start was not taken.
          if (start_key) begin
            error_d = 1'b1;
          end
          if (press && count_q < FULL_COUNT) begin
            digits_d = {digits_q[NUM_DIGITS-2:0], key_digit};
            count_d  = count_q + 3'd1;
          end
        end
      end

      ST_OFFER: begin
        // Digits stay frozen until the timer takes them.
        if (valid_q && tif.time_ready) begin
          digits_d = '0;
          count_d  = 3'd0;
          valid_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        digits_d = '0;
        count_d  = 3'd0;
        valid_d  = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      count_q  <= 3'd0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign tif.time_valid = valid_q;
  assign tif.min_tens   = digits_q[3];
  assign tif.min_ones   = digits_q[2];
  assign tif.sec_tens   = digits_q[1];
  assign tif.sec_ones   = digits_q[0];
  assign digit_count    = count_q;
  assign entry_error    = error_q;

endmodule
`default_nettype wire

// File: doc/time_entry_register.md
# time_entry_register

Consumes the debounced 4-bit digit code from the keypad priority encoder and builds a four-digit MM:SS cook time in BCD, one digit per key press, shifting from the right like a microwave display. On the start key it offers the completed time to the countdown timer over a valid/ready handshake. It then clears itself for the next entry.

## Interface
- MAX_SEC_TENS, 5, largest legal seconds-tens digit; a larger value blocks start.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  keypad entry mode; same signal that drives the encoder's enable.
- encoded  in  4  encoder output: 0 = no key, 1..9 = digit keys, 10..15 = illegal, treated as 0.
- zero_key  in  1  debounced level of the 0 key, because the encoder cannot distinguish it from no key.
- start_key  in  1  single-cycle start request.
- cancel_key  in  1  single-cycle cancel request.
- time_ready  in  1  timer accepts the offered time.
- min_tens, min_ones, sec_tens, sec_ones  out  4 each  BCD digits for display and transfer.
- digit_count  out  3  digits entered, 0..4.
- time_valid  out  1  offered time is stable and awaiting time_ready.
- entry_error  out  1  one-cycle pulse on a rejected start.

## Operation
- **Key value:** k = digit 1..9 if encoded is 1..9; else 0 if zero_key = 1; else NONE.
- **Press event:**
  - Fires when k ≠ NONE and key_prev = NONE.
  - key_prev is the registered k.
  - A held key gives exactly one event; the next event needs at least one NONE cycle between presses.
- **enable = 0:**
  - key_prev is forced to NONE and no press events occur.
  - Digits, state, start and cancel still operate.
- **States:** IDLE, ENTRY, OFFER.
- **IDLE** (digits all 0, count 0):
  - A press of 0 is ignored; there are no leading zeros.
  - A press of 1..9 loads sec_ones, sets count = 1 and moves to ENTRY.
  - start_key and cancel_key have no effect.
- **ENTRY:**
  - A press with count < 4 shifts the display left: min_tens←min_ones, min_ones←sec_tens, sec_tens←sec_ones, sec_ones←k. Count increments.
  - A press with count = 4 is ignored; count saturates.
  - cancel_key clears all digits and count and returns to IDLE.
  - start_key with sec_tens ≤ MAX_SEC_TENS moves to OFFER.
  - start_key with sec_tens > MAX_SEC_TENS pulses entry_error, stays in ENTRY and keeps the digits.
- **OFFER:**
  - time_valid = 1 and the digits are frozen.
  - Presses, start_key and cancel_key are ignored. time_valid never drops before acceptance.
  - time_valid & time_ready clears digits and count and returns to IDLE.
- **Priority in the same cycle:** cancel > start > press. A press coinciding with an accepted start or cancel is discarded.
- Minutes are not range-limited; 99:59 is legal.

## Timing
- **Reset values:** every output is 0, state = IDLE, key_prev = NONE.
- **Reset mid-OFFER:** time_valid drops asynchronously and no transfer occurs.
- **Press latency:** digit, count and state change at the first rising edge where the press condition holds, and are visible in the next cycle.
- **Start latency:** time_valid rises one cycle after start_key is sampled.
- **Error latency:** entry_error is high for exactly the one cycle after the rejected start_key.
- **Handshake:**
  - Transfer happens on the edge where time_valid & time_ready are both 1.
  - time_valid is low and the digits read 0 in the following cycle.
  - time_ready while time_valid = 0 is ignored.
  - time_ready held high accepts on the first OFFER cycle.
- **Registers:** all outputs come directly from registers, with no combinational path from inputs to outputs.

## Structure
- **Shared package microwave_pkg:**
  - State enum {IDLE, ENTRY, OFFER}.
  - KEY_NONE encoding (5-bit key value with a none flag).
  - NUM_DIGITS = 4 and a BCD digit typedef, 4 bits.
- **Sub-module key_press_detector:** maps encoded and zero_key to k and generates the press event with key_prev. It has its own clk/rst and honours enable.
- **Top:** FSM plus the four-digit shift register and count, about 200 lines total.

## Test plan
- **Basic entry:** presses 1, 3, 0, 0 with release gaps → digits 13:00, count 4. A fifth press of 7 is ignored.
- **Leading zero and held key:** 0 in IDLE, then 5 held for 20 cycles → state stays IDLE after the 0; the held 5 gives one event, so 00:05 with count 1.
- **Invalid seconds:** enter 1, 7, 5 (01:75), then start_key → entry_error pulses one cycle, time_valid stays 0, digits kept. Next, cancel_key → all 0, IDLE.
- **Handshake:**
  - Enter 2, 3, 0 (02:30), then start with time_ready = 0 for 5 cycles → time_valid held, digits frozen, presses and cancel ignored.
  - time_ready = 1 → transfer on that edge; time_valid = 0 and digits 0 the next cycle.
- **Simultaneous inputs:** in ENTRY, cancel_key with start_key and a press in the same cycle → IDLE with all digits 0, no time_valid, no error.
- **Reset and enable:**
  - Assert rst asynchronously mid-OFFER → outputs 0 immediately.
  - Hold enable low with encoded = 4 → no press. Raise enable while 4 is still held → one press event, 00:04.
